// File: rtl/rgb_breathe_pkg.sv
// Shared types and constants for the RGB breathing LED driver.
package rgb_breathe_pkg;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HI   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LO   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    R = 2'd0,
    G = 2'd1,
    B = 2'd2
  } color_t;

  localparam int COLOR_COUNT = 3;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/breathe_pwm.sv
// PWM counter, optional square-law gamma (RGB_BREATHE_GAMMA_EN) and registered
// active-low pin drive for the currently selected colour.
module breathe_pwm
  import rgb_breathe_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PWM_BITS-1:0]    duty,
  input  color_t                 color,
  output logic [COLOR_COUNT-1:0] led_n
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_eff;
  logic                lit;

`ifdef RGB_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
  assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_eff = duty;
`endif

  assign lit = (pwm_cnt < duty_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led_n   <= '1;
    end else if (en) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < COLOR_COUNT; i++)
        led_n[i] <= ~(lit && (int'(color) == i));
    end else begin
      led_n <= '1;
    end
  end

endmodule

// File: rtl/rgb_breathe.sv
// Breathing RGB LED driver: prescaled step FSM ramps duty up/down per colour,
// cycling R -> G -> B. Gamma correction selected by RGB_BREATHE_GAMMA_EN.
module rgb_breathe
  import rgb_breathe_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 65536,
  parameter int HOLD_STEPS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       LED_R_,
  output logic       LED_G_,
  output logic       LED_B_,
  output logic [1:0] color,
  output logic [1:0] phase
);

  localparam int PS_W   = cnt_w(STEP_DIV);
  localparam int HOLD_W = cnt_w(HOLD_STEPS);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  logic [PS_W-1:0]        prescaler;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [PWM_BITS-1:0]    duty;
  logic                   step;
  phase_t                 phase_q;
  color_t                 color_q;
  logic [COLOR_COUNT-1:0] led_n;

  assign step  = en && (prescaler == PS_LAST);
  assign phase = phase_q;
  assign color = color_q;

  always_ff @(posedge clk) begin
    if (rst)
      prescaler <= '0;
    else if (en)
      prescaler <= step ? '0 : prescaler + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty     <= '0;
      hold_cnt <= '0;
      phase_q  <= RAMP_UP;
      color_q  <= R;
    end else if (step) begin
      case (phase_q)
        RAMP_UP: begin
          if (duty != DUTY_MAX) duty <= duty + 1'b1;
          // Leave the ramp on the step that lands on full scale.
          if (duty >= DUTY_MAX - 1'b1) begin
            phase_q  <= HOLD_HI;
            hold_cnt <= '0;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            phase_q  <= RAMP_DOWN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (duty != '0) duty <= duty - 1'b1;
          if (duty <= PWM_BITS'(1)) begin
            phase_q  <= HOLD_LO;
            hold_cnt <= '0;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            phase_q  <= RAMP_UP;
            hold_cnt <= '0;
            color_q  <= (color_q == B) ? R : color_t'(color_q + 2'd1);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: phase_q <= RAMP_UP;
      endcase
    end
  end

  breathe_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .duty  (duty),
    .color (color_q),
    .led_n (led_n)
  );

  assign LED_R_ = led_n[0];
  assign LED_G_ = led_n[1];
  assign LED_B_ = led_n[2];

endmodule

// File: tb/tb_rgb_breathe.sv
// Randomised bench for rgb_breathe against a step-count reference model.
module tb_rgb_breathe;

  localparam int N   = 3;
  localparam int S   = 2;
  localparam int H   = 2;
  localparam int MAX = (1 << N) - 1;
  localparam int P   = 2 * MAX + 2 * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       LED_R_, LED_G_, LED_B_;
  logic [1:0] color, phase;

  int checks   = 0;
  int failures = 0;

  rgb_breathe #(.PWM_BITS(N), .STEP_DIV(S), .HOLD_STEPS(H)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .LED_R_ (LED_R_),
    .LED_G_ (LED_G_),
    .LED_B_ (LED_B_),
    .color  (color),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Model: everything follows from e, the number of enabled edges since reset.
  function automatic int duty_of(input int s);
    int r = s % P;
    if (r < MAX)         return r;
    if (r < MAX + H)     return MAX;
    if (r < 2 * MAX + H) return MAX - (r - MAX - H);
    return 0;
  endfunction

  function automatic int phase_of(input int s);
    int r = s % P;
    if (r < MAX)         return 0;
    if (r < MAX + H)     return 1;
    if (r < 2 * MAX + H) return 2;
    return 3;
  endfunction

  function automatic int color_of(input int s);
    return (s / P) % 3;
  endfunction

  function automatic int duty_eff_of(input int d);
`ifdef RGB_BREATHE_GAMMA_EN
    return (d * d) >> N;
`else
    return d;
`endif
  endfunction

  function automatic logic [2:0] pins_of(input int c);
    logic [2:0] p = 3'b111;
    p[color_of(c / S)] = !((c % (1 << N)) < duty_eff_of(duty_of(c / S)));
    return p;
  endfunction

  int         e = 0;
  logic [2:0] exp_led = 3'b111;

  always @(posedge clk) begin
    if (rst) begin
      e       <= 0;
      exp_led <= 3'b111;
    end else if (en) begin
      exp_led <= pins_of(e);
      e       <= e + 1;
    end else begin
      exp_led <= 3'b111;
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({LED_B_, LED_G_, LED_R_} !== 3'b111) begin
        failures++; $display("FAIL reset_leds got=%b exp=111", {LED_B_, LED_G_, LED_R_});
      end
      checks++;
      if ({color, phase} !== 4'b0000) begin
        failures++; $display("FAIL reset_state got=%b exp=0000", {color, phase});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_run(input string name, input int cycles, output int phases[$], output int colors[$]);
    phases = {int'(phase)};
    colors = {int'(color)};
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({LED_B_, LED_G_, LED_R_} !== exp_led) begin
        failures++; $display("FAIL %s_leds e=%0d got=%b exp=%b", name, e, {LED_B_, LED_G_, LED_R_}, exp_led);
      end
      checks++;
      if ({color, phase} !== {2'(color_of(e / S)), 2'(phase_of(e / S))}) begin
        failures++; $display("FAIL %s_state e=%0d got=%b exp=%b", name, e, {color, phase},
                             {2'(color_of(e / S)), 2'(phase_of(e / S))});
      end
      if (int'(phase) != phases[$]) phases.push_back(int'(phase));
      if (int'(color) != colors[$]) colors.push_back(int'(color));
    end
  endtask

  task automatic test_one_colour();
    int ph[$], co[$];
    int exp_ph[$] = '{0, 1, 2, 3, 0};
    test_reset();
    test_run("one_colour", 36, ph, co);
    checks++;
    if (ph != exp_ph) begin
      failures++; $display("FAIL phase_order got=%p exp=%p", ph, exp_ph);
    end
    checks++;
    if (color !== 2'd1) begin
      failures++; $display("FAIL colour_at_36 got=%0d exp=1", color);
    end
  endtask

  task automatic test_colour_cycle();
    int ph[$], co[$];
    int exp_co[$] = '{0, 1, 2, 0};
    test_reset();
    test_run("cycle", 108, ph, co);
    checks++;
    if (co != exp_co) begin
      failures++; $display("FAIL colour_order got=%p exp=%p", co, exp_co);
    end
  endtask

  task automatic test_en_pause();
    int ph[$], co[$];
    int bound = 0;
    logic [3:0] held;
    while (phase_of(e / S) != 2 && bound < 100) begin
      @(posedge clk); #1; bound++;
    end
    checks++;
    if (bound >= 100) begin
      failures++; $display("FAIL pause_wait got=timeout exp=RAMP_DOWN");
    end
    held = {color, phase};
    en = 1'b0;
    test_run("pause", 10, ph, co);
    checks++;
    if ({color, phase} !== held) begin
      failures++; $display("FAIL pause_hold got=%b exp=%b", {color, phase}, held);
    end
    en = 1'b1;
    test_run("resume", 30, ph, co);
  endtask

  task automatic test_random_en();
    int ph[$], co[$];
    for (int k = 0; k < 30; k++) begin
      en = ($urandom_range(0, 3) != 0);
      test_run("random", $urandom_range(1, 12), ph, co);
      checks++;
      if (color === 2'd3) begin
        failures++; $display("FAIL colour_range got=3 exp=0..2");
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bound = 0;
    while (!(color_of(e / S) == 2 && phase_of(e / S) == 1) && bound < 200) begin
      @(posedge clk); #1; bound++;
    end
    checks++;
    if (bound >= 200) begin
      failures++; $display("FAIL mid_wait got=timeout exp=blue HOLD_HI");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({color, phase, LED_B_, LED_G_, LED_R_} !== 7'b0000111) begin
      failures++; $display("FAIL mid_reset got=%b exp=0000111", {color, phase, LED_B_, LED_G_, LED_R_});
    end
    begin
      int ph[$], co[$];
      test_run("after_reset", 20, ph, co);
    end
  endtask

  initial begin
    test_reset();
    test_one_colour();
    test_colour_cycle();
    test_en_pause();
    test_random_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
